// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, glitch-filtered start bit,
// optional parity, 1 or 2 checked stop bits, one-cycle rx_valid per frame.
module uart_rx_cfg #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = 4;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           sync;
  logic                 sync_dly;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag;
  logic                 frame_flag;

  logic rx_bit;
  logic start_edge;
  logic mid_start;
  logic bit_tick;
  logic done;

  // Line is asynchronous; sync[1] is the first safe copy, sync_dly finds the fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b11;
      sync_dly <= 1'b1;
    end else begin
      sync     <= {sync[0], rs232_rx};
      sync_dly <= sync[1];
    end
  end

  always_comb begin
    rx_bit     = sync[1];
    start_edge = !sync[1] && sync_dly;
    mid_start  = (state == S_START) && (cnt == CNT_HALF);
    bit_tick   = (state inside {S_DATA, S_PARITY, S_STOP}) && (cnt == CNT_MAX);
    done       = (state == S_STOP) && bit_tick && (bit_cnt == LAST_STOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_edge) state_nxt = S_START;
      S_START:  if (mid_start) state_nxt = rx_bit ? S_IDLE : S_DATA;
      S_DATA:   if (bit_tick && (bit_cnt == LAST_DATA)) state_nxt = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_nxt = S_STOP;
      // Leaving at mid stop bit leaves half a bit to catch the next start edge.
      S_STOP:   if (done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == S_IDLE || mid_start || bit_tick) cnt <= '0;
      else                                          cnt <= cnt + CW'(1);
      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_tick)      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      par_flag   <= 1'b0;
      frame_flag <= 1'b0;
    end else begin
      if (state == S_IDLE && start_edge) begin
        par_flag   <= 1'b0;
        frame_flag <= 1'b0;
      end
      if (state == S_DATA && bit_tick) shreg <= {rx_bit, shreg[DATA_BITS-1:1]};
      if (state == S_PARITY && bit_tick) par_flag <= rx_bit ^ (^shreg) ^ PAR_ODD;
      if (state == S_STOP && bit_tick && !rx_bit) frame_flag <= 1'b1;
    end
  end

  // rx_valid is a bare pulse with no ready: the consumer must take rx_data and
  // both flags in that cycle; they are held until the next pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= done;
      rx_busy  <= (state_nxt != S_IDLE);
      if (done) begin
        rx_data    <= shreg;
        parity_err <= PAR_EN & par_flag;
        frame_err  <= frame_flag | ~rx_bit;
      end
    end
  end

endmodule
